// File: rtl/ahb_sram_slave.sv
// ============================================================================
// Module   : ahb_sram_slave
// Brief    : AHB-Lite SRAM slave with programmable wait states, byte lanes
//            and write-to-read bypass. Define AHB_SLAVE_ERR_RESP_EN to answer
//            illegal transfers with a two-cycle ERROR response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ahb_sram_slave #(
  parameter int          DATA_WDT   = 32,
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  input  logic [1:0]          i_wait,
  output logic                o_hready,
  output logic [1:0]          o_hresp,
  output logic [DATA_WDT-1:0] o_hrdata
);

  localparam int         c_depth = 1 << DEPTH_LOG2;
  localparam logic [1:0] c_okay  = 2'b00;
`ifdef AHB_SLAVE_ERR_RESP_EN
  localparam logic [1:0] c_error = 2'b01;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
`ifdef AHB_SLAVE_ERR_RESP_EN
    S_ERR1,
    S_ERR2,
`endif
    S_DATA
  } state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [1:0]            r_lo;
  logic [1:0]            r_size;
  logic                  r_write;
  logic                  r_legal;
  logic [1:0]            r_cnt;
  logic [DATA_WDT-1:0]   r_mem [0:c_depth-1];

  logic [31:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_accept;
  logic                  w_legal;
  logic [3:0]            w_be;
  logic                  w_wr_en;
  logic                  w_bypass;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DATA_WDT-1:0]   w_rd_word;
  logic                  w_unused_hburst;

  assign w_unused_hburst = ^i_hburst;

  always_comb begin
    w_off    = i_haddr - BASE_ADDR;
    w_idx    = w_off[DEPTH_LOG2+1:2];
    w_accept = i_hsel && i_hready && i_htrans[1];
    w_legal  = (w_off[31:DEPTH_LOG2+2] == '0) && !i_hsize[2] && (i_hsize[1:0] != 2'b11)
            && !((i_hsize[1:0] == 2'b01) && w_off[0])
            && !((i_hsize[1:0] == 2'b10) && (w_off[1:0] != 2'b00));

    case (r_size)
      2'b00:   w_be = 4'b0001 << r_lo;
      2'b01:   w_be = r_lo[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase

    w_wr_en  = (r_state == S_DATA) && r_write && r_legal;
    // A read accepted during a write's DATA cycle sees that write's lanes.
    w_bypass = w_wr_en && (r_idx == w_idx);
    w_rd_idx = (r_state == S_WAIT) ? r_idx : w_idx;

    w_rd_word = r_mem[w_rd_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_bypass && w_be[b]) w_rd_word[8*b +: 8] = i_hwdata[8*b +: 8];
    end
  end

  always_ff @(posedge i_hclk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_lo     <= '0;
      r_size   <= '0;
      r_write  <= 1'b0;
      r_legal  <= 1'b0;
      r_cnt    <= '0;
      o_hready <= 1'b1;
      o_hresp  <= c_okay;
      o_hrdata <= '0;
    end else begin
      o_hready <= 1'b1;
      o_hresp  <= c_okay;
      o_hrdata <= '0;
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 2'd1) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            if (!r_write) o_hrdata <= w_rd_word;
          end else begin
            r_cnt    <= r_cnt - 2'd1;
            o_hready <= 1'b0;
          end
        end
`ifdef AHB_SLAVE_ERR_RESP_EN
        S_ERR1: begin
          r_state <= S_ERR2;
          o_hresp <= c_error;
        end
`endif
        default: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            r_lo    <= w_off[1:0];
            r_size  <= i_hsize[1:0];
            r_write <= i_hwrite;
            r_legal <= w_legal;
            r_cnt   <= '0;
            if (!w_legal) begin
`ifdef AHB_SLAVE_ERR_RESP_EN
              r_state  <= S_ERR1;
              o_hready <= 1'b0;
              o_hresp  <= c_error;
`else
              r_state  <= S_DATA;
`endif
            end else if (i_wait != 2'd0) begin
              r_state  <= S_WAIT;
              r_cnt    <= i_wait;
              o_hready <= 1'b0;
            end else begin
              r_state <= S_DATA;
              if (!i_hwrite) o_hrdata <= w_rd_word;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter DATA_WDT, default 32, data bus width (fixed to 32 in this revision).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of memory depth in 32-bit words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0, aligned to 4*2^DEPTH_LOG2.
REQ-004 SHALL have port i_hclk  in  1  AHB clock, the only clock; all logic samples on its rising edge.
REQ-005 SHALL have port i_hreset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the following AHB request inputs:
- i_hsel  in  1  slave select.
- i_haddr  in  32  address.
- i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- i_hwrite  in  1  write when 1.
- i_hsize  in  3  transfer size.
- i_hburst  in  3  burst type; accepted and ignored.
- i_hwdata  in  DATA_WDT  write data.
- i_hready  in  1  bus-wide HREADY.
REQ-007 SHALL have the following AHB response outputs:
- o_hready  out  1  slave HREADYOUT.
- o_hresp  out  2  OKAY=0, ERROR=1, SPLIT=2, RETRY=3.
- o_hrdata  out  DATA_WDT  read data.
REQ-008 SHALL have port i_wait  in  2  number of wait states for the next accepted transfer.

Function
REQ-009 SHALL accept an address phase when i_hsel && i_hready && i_htrans is NONSEQ or SEQ.
REQ-010 SHALL capture haddr, hwrite, hsize and i_wait on acceptance.
REQ-011 SHALL give a zero-wait OKAY data phase when the address phase is IDLE or BUSY, or i_hsel=0; no memory access occurs.
REQ-012 SHALL implement the state machine IDLE, WAIT, DATA, ERR1, ERR2.
REQ-013 SHALL go IDLE->WAIT on an accepted legal transfer with captured wait>0, loading the wait counter with wait.
REQ-014 SHALL go IDLE->DATA on an accepted legal transfer with wait=0.
REQ-015 SHALL decrement the counter in WAIT with o_hready=0, o_hresp=OKAY, moving to DATA when the counter reaches 1.
REQ-016 SHALL drive o_hready=1, o_hresp=OKAY in DATA and complete the transfer there.
REQ-017 SHALL, in DATA, accept a new address phase in the same cycle per REQ-009 (back-to-back pipelined transfers); with no new transfer it returns to IDLE.
REQ-018 SHALL treat a transfer as illegal when (a) haddr-BASE_ADDR >= 4*2^DEPTH_LOG2 (unsigned), (b) hsize > 2, or (c) haddr is misaligned to hsize.
REQ-019 SHALL handle illegal transfers per Configuration; wait states are not applied to them.
REQ-020 SHALL commit writes in the DATA cycle, using i_hwdata valid in that cycle.
REQ-021 SHALL write only the byte lanes selected little-endian by hsize and haddr[1:0]: byte -> lane haddr[1:0]; halfword -> lanes {haddr[1],0} and {haddr[1],1}; word -> all lanes.
REQ-022 SHALL present read data on o_hrdata in the DATA cycle as the full 32-bit word at (haddr-BASE_ADDR)>>2; o_hrdata is 0 in all other cycles.
REQ-023 SHALL return the newly written data when a read's DATA cycle immediately follows a write's DATA cycle to the same word (write-to-read bypass, no extra wait).
REQ-024 SHALL never issue SPLIT or RETRY.
REQ-025 SHALL not reset memory contents.

Reset
REQ-026 SHALL, while i_hreset=1, force state IDLE, counter 0, o_hready=1, o_hresp=OKAY, o_hrdata=0.
REQ-027 SHALL abandon an in-flight transfer on reset assertion mid-transfer with no memory write, then resume normally on the first edge after release.

Configuration
REQ-028 SHALL, with macro AHB_SLAVE_ERR_RESP_EN defined, send an illegal transfer IDLE->ERR1 (o_hready=0, o_hresp=ERROR), then ERR2 (o_hready=1, o_hresp=ERROR), then IDLE.
REQ-029 SHALL, with AHB_SLAVE_ERR_RESP_EN defined, not accept a new address phase in ERR1, and accept one in ERR2 per REQ-009; no memory write occurs for the illegal transfer.
REQ-030 SHALL, without AHB_SLAVE_ERR_RESP_EN, complete an illegal transfer as zero-wait OKAY: write dropped, o_hrdata=0, ERR1/ERR2 absent.

Verification
REQ-031 SHALL verify: NONSEQ write word 0xDEADBEEF @BASE+0x10, wait=0, then NONSEQ read @BASE+0x10 back-to-back -> both OKAY zero-wait, o_hrdata=0xDEADBEEF.
REQ-032 SHALL verify: write word 0x11223344 @BASE+0x0, then byte write 0xAA on lane 2 @BASE+0x2, then read @BASE+0x0 -> 0x11AA3344.
REQ-033 SHALL verify: read with i_wait=3 -> o_hready low 3 cycles, then high with OKAY and data.
REQ-034 SHALL verify: read @BASE+4*2^DEPTH_LOG2 with macro -> o_hready 0 then 1 with hresp ERROR both cycles; without macro -> zero-wait OKAY, o_hrdata=0.
REQ-035 SHALL verify: INCR4 burst NONSEQ,BUSY,SEQ,SEQ,SEQ of words 1..4 @BASE+0x20 -> BUSY gets zero-wait OKAY, readback gives 1,2,3,4.
REQ-036 SHALL verify: i_hreset pulse during WAIT of a write -> o_hready=1, o_hresp=OKAY immediately, target word unchanged.
